// File: rtl/dcache_arbiter.sv
// dcache_arbiter: two-requester arbiter in front of a single-port dcache array.
// Each accepted access takes three cycles: grant (IDLE), array access (ACCESS),
// completion pulse (RESP).
// Build option DCACHE_ARB_RR_EN: when defined, simultaneous requests are resolved
// round-robin. When undefined, port 0 always wins a tie and no pointer is kept.
module dcache_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  // requester 0: core data port
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [DATA_W/8-1:0] p0_mask,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  output logic                p0_gnt,
  output logic                p0_done,
  output logic [DATA_W-1:0]   p0_rdata,
  // requester 1: debug/DMA port
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [DATA_W/8-1:0] p1_mask,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p1_gnt,
  output logic                p1_done,
  output logic [DATA_W-1:0]   p1_rdata,
  // dcache array side
  output logic                mem_wr_req,
  output logic [DATA_W/8-1:0] mem_wr_mask,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                any_req;
  logic                win_id;
  logic                grant;

  logic                cap_id;
  logic                cap_we;
  logic [DATA_W/8-1:0] cap_mask;
  logic [ADDR_W-1:0]   cap_addr;
  logic [DATA_W-1:0]   cap_wdata;

  assign any_req = p0_req | p1_req;

  // A grant can only be issued from IDLE; the reset term keeps gnt low while
  // rst_n is held low even though requesters may still be asserting req.
  assign grant = (state == IDLE) && any_req && rst_n;

`ifdef DCACHE_ARB_RR_EN
  logic rr_ptr;

  // Tie-break pointer: holds the port that wins the next simultaneous request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (grant) begin
      rr_ptr <= ~win_id;
    end
  end

  // Winner selection: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    win_id = 1'b0;
    if (p0_req && p1_req) begin
      win_id = rr_ptr;
    end else if (p1_req) begin
      win_id = 1'b1;
    end
  end
`else
  // Fixed priority: port 1 wins only when port 0 is not requesting.
  assign win_id = ~p0_req;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: IDLE -> ACCESS on a grant, then ACCESS -> RESP -> IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the winner's attributes so the requester may change them after gnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_id    <= 1'b0;
      cap_we    <= 1'b0;
      cap_mask  <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (grant) begin
      cap_id    <= win_id;
      cap_we    <= win_id ? p1_we    : p0_we;
      cap_mask  <= win_id ? p1_mask  : p0_mask;
      cap_addr  <= win_id ? p1_addr  : p0_addr;
      cap_wdata <= win_id ? p1_wdata : p0_wdata;
    end
  end

  // Read data is latched at the end of ACCESS into the winner's port only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_rdata <= '0;
      p1_rdata <= '0;
    end else if (state == ACCESS && !cap_we) begin
      if (cap_id) begin
        p1_rdata <= mem_rdata;
      end else begin
        p0_rdata <= mem_rdata;
      end
    end
  end

  // Output decode: grants in IDLE, array drive in ACCESS, done pulse in RESP.
  always_comb begin
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    p0_done     = 1'b0;
    p1_done     = 1'b0;
    mem_wr_req  = 1'b0;
    mem_wr_mask = '0;
    mem_wdata   = '0;
    mem_addr    = '0;
    busy        = (state != IDLE);
    case (state)
      IDLE: begin
        p0_gnt = grant & ~win_id;
        p1_gnt = grant &  win_id;
      end
      ACCESS: begin
        mem_wr_req  = cap_we;
        mem_wr_mask = cap_mask;
        mem_wdata   = cap_wdata;
        mem_addr    = cap_addr;
      end
      RESP: begin
        p0_done = ~cap_id;
        p1_done =  cap_id;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter: directed and randomized checks of dcache_arbiter against a
// transaction-level model (arbiter free time, predicted access and done cycles,
// reference memory contents). Follows DCACHE_ARB_RR_EN for the arbitration rule.
module tb_dcache_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MW     = DATA_W / 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [MW-1:0]     p0_mask, p1_mask;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p0_done, p1_gnt, p1_done;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic              mem_wr_req;
  logic [MW-1:0]     mem_wr_mask;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  always #5 clk = ~clk;

  dcache_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_mask(p0_mask), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_mask(p1_mask), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .mem_wr_req(mem_wr_req), .mem_wr_mask(mem_wr_mask), .mem_wdata(mem_wdata),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy)
  );

  // Small dcache array: combinational read, byte-masked write on the clock edge.
  logic [DATA_W-1:0] dmem [16];
  assign mem_rdata = dmem[mem_addr[5:2]];
  always @(posedge clk) begin
    if (mem_wr_req) begin
      for (int b = 0; b < MW; b++) begin
        if (mem_wr_mask[b]) dmem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  int cyc      = 0;
  int free_at  = 0;
  int acc_cyc  = -1;
  int resp_cyc = -1;
  bit m_port, m_we, next_pri;
  logic [MW-1:0]     m_mask;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] ref_mem [16];
  logic [DATA_W-1:0] ref_rdata [2];

  // Requester drivers: an op stays asserted until the model grants it.
  bit                drv_act [2];
  bit                drv_we [2];
  logic [MW-1:0]     drv_mask [2];
  logic [ADDR_W-1:0] drv_addr [2];
  logic [DATA_W-1:0] drv_wdata [2];

  // Grants seen on the DUT pins, for sequence checks.
  int gq_port [$];
  int gq_cyc [$];
  logic              obs_p0_done, obs_p1_done, obs_wr_req;
  logic [DATA_W-1:0] obs_p0_rdata, obs_p1_rdata;
  logic [ADDR_W-1:0] obs_addr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus();
    p0_req = drv_act[0]; p0_we = drv_we[0]; p0_mask = drv_mask[0];
    p0_addr = drv_addr[0]; p0_wdata = drv_wdata[0];
    p1_req = drv_act[1]; p1_we = drv_we[1]; p1_mask = drv_mask[1];
    p1_addr = drv_addr[1]; p1_wdata = drv_wdata[1];
  endtask

  task automatic setOp(input int p, input bit we, input logic [MW-1:0] mask,
                       input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    drv_act[p] = 1'b1; drv_we[p] = we; drv_mask[p] = mask;
    drv_addr[p] = addr; drv_wdata[p] = wdata;
  endtask

  task automatic setRandomOp(input int p);
    setOp(p, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          32'($urandom_range(0, 15)) << 2, $urandom);
  endtask

  function automatic bit pickWinner();
`ifdef DCACHE_ARB_RR_EN
    if (drv_act[0] && drv_act[1]) return next_pri;
`endif
    return drv_act[0] ? 1'b0 : 1'b1;
  endfunction

  // One clock: drive, compare every output at the falling edge, advance model.
  task automatic runCycle();
    bit idle, any, win, in_acc;
    logic [31:0] e_g0, e_g1;
    applyStimulus();
    @(negedge clk);
    idle   = (cyc >= free_at);
    any    = drv_act[0] | drv_act[1];
    win    = pickWinner();
    in_acc = (cyc == acc_cyc);
    e_g0   = 32'(idle && any && !win);
    e_g1   = 32'(idle && any && win);
    if (p0_gnt === 1'b1) begin gq_port.push_back(0); gq_cyc.push_back(cyc); end
    if (p1_gnt === 1'b1) begin gq_port.push_back(1); gq_cyc.push_back(cyc); end
    obs_p0_done = p0_done; obs_p1_done = p1_done; obs_wr_req = mem_wr_req;
    obs_p0_rdata = p0_rdata; obs_p1_rdata = p1_rdata; obs_addr = mem_addr;
    checkOutput("p0_gnt", 32'(p0_gnt), e_g0);
    checkOutput("p1_gnt", 32'(p1_gnt), e_g1);
    checkOutput("busy", 32'(busy), 32'(!idle));
    checkOutput("mem_wr_req", 32'(mem_wr_req), 32'(in_acc && m_we));
    checkOutput("mem_addr", mem_addr, in_acc ? m_addr : 32'd0);
    checkOutput("mem_wdata", mem_wdata, in_acc ? m_wdata : 32'd0);
    checkOutput("mem_wr_mask", 32'(mem_wr_mask), in_acc ? 32'(m_mask) : 32'd0);
    checkOutput("p0_done", 32'(p0_done), 32'(cyc == resp_cyc && !m_port));
    checkOutput("p1_done", 32'(p1_done), 32'(cyc == resp_cyc && m_port));
    checkOutput("p0_rdata", p0_rdata, ref_rdata[0]);
    checkOutput("p1_rdata", p1_rdata, ref_rdata[1]);
    if (idle && any) begin
      m_port = win; m_we = drv_we[win]; m_mask = drv_mask[win];
      m_addr = drv_addr[win]; m_wdata = drv_wdata[win];
      acc_cyc = cyc + 1; resp_cyc = cyc + 2; free_at = cyc + 3;
      next_pri = ~win;
      drv_act[win] = 1'b0;
    end
    @(posedge clk);
    if (cyc == acc_cyc) begin
      if (m_we) begin
        for (int b = 0; b < MW; b++) begin
          if (m_mask[b]) ref_mem[m_addr[5:2]][8*b +: 8] = m_wdata[8*b +: 8];
        end
      end else begin
        ref_rdata[m_port] = ref_mem[m_addr[5:2]];
      end
    end
    cyc++;
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must clear without waiting for a clock.
  task automatic resetMid();
    #2 rst_n = 1'b0;
    p0_req = 1'b1; p1_req = 1'b1;
    #1;
    checkOutput("rst_p0_gnt", 32'(p0_gnt), 32'd0);
    checkOutput("rst_p1_gnt", 32'(p1_gnt), 32'd0);
    checkOutput("rst_p0_done", 32'(p0_done), 32'd0);
    checkOutput("rst_p1_done", 32'(p1_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_wr_req", 32'(mem_wr_req), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_mem_wr_mask", 32'(mem_wr_mask), 32'd0);
    checkOutput("rst_p0_rdata", p0_rdata, 32'd0);
    checkOutput("rst_p1_rdata", p1_rdata, 32'd0);
    acc_cyc = -1; resp_cyc = -1; next_pri = 1'b0;
    ref_rdata[0] = '0; ref_rdata[1] = '0;
    drv_act[0] = 1'b0; drv_act[1] = 1'b0;
    applyStimulus();
    repeat (2) begin @(posedge clk); cyc++; end
    #1 rst_n = 1'b1;
    free_at = cyc;
  endtask

  task automatic drainAll();
    for (int k = 0; k < 40 && (drv_act[0] || drv_act[1] || cyc < free_at); k++) runCycle();
    checkOutput("drain_pending", 32'(drv_act[0] || drv_act[1] || cyc < free_at), 32'd0);
  endtask

  initial begin
    int rem [2];
    rst_n = 1'b0;
    for (int i = 0; i < 16; i++) begin dmem[i] = '0; ref_mem[i] = '0; end
    for (int p = 0; p < 2; p++) begin
      drv_act[p] = 1'b0; drv_we[p] = 1'b0; drv_mask[p] = '0;
      drv_addr[p] = '0; drv_wdata[p] = '0; ref_rdata[p] = '0;
    end
    applyStimulus();
    @(posedge clk); #1;
    resetMid();

    // p0 full-mask write of 0xDEADBEEF to 0x04.
    setOp(0, 1'b1, 4'hF, 32'h04, 32'hDEADBEEF);
    gq_port.delete(); gq_cyc.delete();
    runCycle();
    runCycle();
    checkOutput("req027_wr_req", 32'(obs_wr_req), 32'd1);
    checkOutput("req027_addr", obs_addr, 32'h04);
    runCycle();
    checkOutput("req027_done", 32'(obs_p0_done), 32'd1);

    // p1 reads it back; p0_rdata must stay untouched.
    setOp(1, 1'b0, 4'h0, 32'h04, 32'h0);
    runCycle();
    runCycle();
    checkOutput("req028_wr_req", 32'(obs_wr_req), 32'd0);
    runCycle();
    checkOutput("req028_done", 32'(obs_p1_done), 32'd1);
    checkOutput("req028_rdata", obs_p1_rdata, 32'hDEADBEEF);
    checkOutput("req028_p0_rdata", obs_p0_rdata, 32'h0);

    // Both ports hold req continuously for four reads each.
    gq_port.delete(); gq_cyc.delete();
    rem[0] = 4; rem[1] = 4;
    for (int k = 0; k < 60 && (rem[0] + rem[1] > 0 || drv_act[0] || drv_act[1] || cyc < free_at); k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!drv_act[p] && rem[p] > 0) begin
          setOp(p, 1'b0, 4'h0, 32'($urandom_range(0, 15)) << 2, 32'h0);
          rem[p]--;
        end
      end
      runCycle();
    end
    checkOutput("req029_count", 32'(gq_port.size()), 32'd8);
    for (int i = 0; i < gq_port.size(); i++) begin
`ifdef DCACHE_ARB_RR_EN
      checkOutput("req029_order", 32'(gq_port[i]), 32'(i % 2));
`else
      checkOutput("req029_order", 32'(gq_port[i]), (i < 4) ? 32'd0 : 32'd1);
`endif
      if (i > 0) checkOutput("req029_spacing", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'd3);
    end

    // p1 raises req during p0's ACCESS; it waits for the next IDLE cycle.
    gq_port.delete(); gq_cyc.delete();
    setOp(0, 1'b0, 4'h0, 32'h08, 32'h0);
    runCycle();
    setOp(1, 1'b0, 4'h0, 32'h04, 32'h0);
    drainAll();
    checkOutput("req030_count", 32'(gq_port.size()), 32'd2);
    if (gq_port.size() == 2) begin
      checkOutput("req030_port", 32'(gq_port[1]), 32'd1);
      checkOutput("req030_gap", 32'(gq_cyc[1] - gq_cyc[0]), 32'd3);
    end

    // Reset during ACCESS of a p0 read; afterwards port 0 wins a tie.
    setOp(0, 1'b0, 4'h0, 32'h04, 32'h0);
    runCycle();
    resetMid();
    gq_port.delete(); gq_cyc.delete();
    setOp(0, 1'b0, 4'h0, 32'h04, 32'h0);
    setOp(1, 1'b0, 4'h0, 32'h0C, 32'h0);
    runCycle();
    checkOutput("req031_count", 32'(gq_port.size()), 32'd1);
    if (gq_port.size() == 1) checkOutput("req031_port", 32'(gq_port[0]), 32'd0);
    drainAll();

    // Randomized traffic from both requesters, including zero-mask writes.
    for (int k = 0; k < 400; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!drv_act[p] && $urandom_range(0, 2) == 0) setRandomOp(p);
      end
      runCycle();
    end
    drainAll();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
